// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO
// register pair. One multiplier or quotient bit per cycle, then a sign-fix
// cycle that commits the result. MTHI/MTLO are serviced directly in IDLE.
//
// Handshake: an instruction is taken on a rising edge where state is IDLE and
// op_valid_i is high with a HI/LO-class opcode. While busy, a pending
// op_valid_i or mf_req_i raises stall_o and the instruction is held upstream
// until the first cycle busy_o is low, at which point it is taken.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             op_valid_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_value_i,
  input  logic [WIDTH-1:0] rt_value_i,
  input  logic             mf_req_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [1:0]       state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opa_q;     // multiplier (mul) or dividend (div), shifted out
  logic [WIDTH-1:0]     opb_q;     // multiplicand (mul) or divisor (div)
  logic [WIDTH-1:0]     rs_raw_q;  // raw dividend, returned in HI on divide by zero
  logic                 is_div_q;
  logic                 neg_q;     // sign(rs) ^ sign(rt) for signed ops
  logic                 rs_neg_q;  // remainder sign for DIV
  logic                 div_zero_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 done_q;

  // Opcode decode and operand magnitudes at issue.
  logic             is_muldiv, is_hilo, is_signed_op, is_div_op;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  // Per-iteration step results and sign-fixed commit values.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]     div_rem_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_acc_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   hi_d, lo_d;

  // Decode, iteration datapath and final sign correction.
  always_comb begin
    is_muldiv    = (op_i >= 3'd1) && (op_i <= 3'd4);
    is_hilo      = (op_i >= 3'd1) && (op_i <= 3'd6);
    is_signed_op = (op_i == 3'd1) || (op_i == 3'd3);
    is_div_op    = (op_i == 3'd3) || (op_i == 3'd4);
    rs_neg       = is_signed_op & rs_value_i[WIDTH-1];
    rt_neg       = is_signed_op & rt_value_i[WIDTH-1];
    rs_mag       = rs_neg ? -rs_value_i : rs_value_i;
    rt_mag       = rt_neg ? -rt_value_i : rt_value_i;

    // Shift-add: add multiplicand into the upper half, shift right one bit.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opa_q[0] ? {1'b0, opb_q} : '0);
    mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: remainder in the upper half, quotient bits shift in
    // at the bottom. Since remainder < divisor, the difference fits WIDTH bits.
    div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
    div_ge     = (div_rem_sh >= {1'b0, opb_q});
    div_diff   = div_rem_sh[WIDTH-1:0] - opb_q;
    div_acc_d  = {(div_ge ? div_diff : div_rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rs_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    if (!is_div_q) begin
      hi_d = prod_fix[2*WIDTH-1:WIDTH];
      lo_d = prod_fix[WIDTH-1:0];
    end else if (div_zero_q) begin
      hi_d = rs_raw_q;
      lo_d = '1;
    end else begin
      hi_d = rem_fix;
      lo_d = quo_fix;
    end
  end

  // Sequencer FSM with all architectural and working state.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      rs_raw_q   <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rs_neg_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (op_valid_i && is_muldiv) begin
            opa_q      <= is_div_op ? rs_mag : rt_mag;
            opb_q      <= is_div_op ? rt_mag : rs_mag;
            rs_raw_q   <= rs_value_i;
            is_div_q   <= is_div_op;
            neg_q      <= rs_neg ^ rt_neg;
            rs_neg_q   <= rs_neg;
            div_zero_q <= is_div_op && (rt_value_i == '0);
            acc_q      <= '0;
            cnt_q      <= CW'(WIDTH - 1);
            state_q    <= S_CALC;
          end else if (op_valid_i && (op_i == 3'd5)) begin
            hi_q <= rs_value_i;
          end else if (op_valid_i && (op_i == 3'd6)) begin
            lo_q <= rs_value_i;
          end
        end
        S_CALC: begin
          acc_q <= is_div_q ? div_acc_d : mul_acc_d;
          opa_q <= is_div_q ? (opa_q << 1) : (opa_q >> 1);
          if (cnt_q == '0) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign stall_o = busy_o & ((op_valid_i & is_hilo) | mf_req_i);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: reset, mul/div results and latency,
// stall/hold behaviour, MTHI/MTLO and reset abort.
module tb_muldiv_sequencer;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset_n;
  logic         op_valid;
  logic [2:0]   op;
  logic [W-1:0] rs, rt;
  logic         mf_req;
  logic [W-1:0] hi, lo;
  logic         busy, stall, done;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .op_valid_i (op_valid),
    .op_i       (op),
    .rs_value_i (rs),
    .rt_value_i (rt),
    .mf_req_i   (mf_req),
    .hi_o       (hi),
    .lo_o       (lo),
    .busy_o     (busy),
    .stall_o    (stall),
    .done_o     (done),
    .state_o    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at the falling edge of the first cycle after issue; returns the
  // cycle index (1 = first cycle after issue) at which done is seen.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      if (done) begin
        cyc = k;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] opc, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int cyc, bc;
    logic [W-1:0] xh, xl;
    @(negedge clk);
    op_valid = 1'b1; op = opc; rs = a; rt = b;
    exp_q.push_back(eh);
    exp_q.push_back(el);
    @(negedge clk);
    op_valid = 1'b0;
    rs = $urandom; rt = $urandom;   // operands must already be latched
    wait_done(cyc, bc);
    check({tag, ".latency"}, cyc, 34);
    check({tag, ".busy_cycles"}, bc, 33);
    xh = exp_q.pop_front();
    xl = exp_q.pop_front();
    check({tag, ".hi"}, hi, xh);
    check({tag, ".lo"}, lo, xl);
    check({tag, ".busy_at_done"}, busy, 0);
    @(negedge clk);
    check({tag, ".done_single"}, done, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stall_cnt, low_at, cyc, bc, done_cnt;
    reset_n = 1'b0; op_valid = 1'b0; op = 3'd0; rs = '0; rt = '0; mf_req = 1'b0;
    do_reset();
    check("rst.hi", hi, 0);
    check("rst.lo", lo, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.stall", stall, 0);
    check("rst.state", state_dbg, 0);

    // Load nonzero HI/LO, then reset must clear them.
    @(negedge clk); op_valid = 1'b1; op = 3'd5; rs = 32'hDEAD_BEEF;
    @(negedge clk); op = 3'd6; rs = 32'hCAFE_F00D;
    @(negedge clk); op_valid = 1'b0;
    check("pre.hi", hi, 32'hDEAD_BEEF);
    check("pre.lo", lo, 32'hCAFE_F00D);
    do_reset();
    check("rst2.hi", hi, 0);
    check("rst2.lo", lo, 0);

    // op 0 is ignored: no accept, no busy.
    @(negedge clk); op_valid = 1'b1; op = 3'd0;
    @(negedge clk); check("op0.busy", busy, 0); op_valid = 1'b0;

    run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  3'd1, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg",   3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_min",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu",      3'd4, 32'd100,       32'd7,         32'd2,         32'd14);
    run_op("divu_z",    3'd4, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
    run_op("div_z",     3'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("mult_pp",   3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F);

    // MULT, then a second MULT held on op_valid plus MFHI held on mf_req.
    @(negedge clk); op_valid = 1'b1; op = 3'd1; rs = 32'hFFFF_FFF9; rt = 32'd3;
    @(negedge clk); rs = 32'd5; rt = 32'd6; mf_req = 1'b1;
    stall_cnt = 0; low_at = 0;
    for (int k = 1; k <= 60; k++) begin
      if (!stall) begin
        low_at = k;
        break;
      end
      stall_cnt++;
      @(negedge clk);
    end
    check("hold.stall_cycles", stall_cnt, 33);
    check("hold.stall_low_at", low_at, 34);
    check("hold.done", done, 1);
    check("hold.mfhi", hi, 32'hFFFF_FFFF);
    check("hold.lo", lo, 32'hFFFF_FFEB);
    @(negedge clk);
    op_valid = 1'b0; mf_req = 1'b0;
    check("hold.second_accepted", busy, 1);
    wait_done(cyc, bc);
    check("hold2.latency", cyc, 34);
    check("hold2.hi", hi, 32'd0);
    check("hold2.lo", lo, 32'd30);

    // mf_req while idle never stalls.
    @(negedge clk); mf_req = 1'b1;
    #1 check("idle_mf.stall", stall, 0);
    @(negedge clk); mf_req = 1'b0;

    // MTHI then MTLO back to back.
    op_valid = 1'b1; op = 3'd5; rs = 32'h1234_5678;
    #1 check("mthi.stall", stall, 0);
    @(negedge clk);
    check("mthi.hi", hi, 32'h1234_5678);
    op = 3'd6; rs = 32'h9ABC_DEF0;
    #1 check("mtlo.stall", stall, 0);
    @(negedge clk);
    op_valid = 1'b0;
    check("mtlo.lo", lo, 32'h9ABC_DEF0);
    check("mtlo.busy", busy, 0);

    // Reset in the middle of CALC aborts without touching HI/LO via done.
    @(negedge clk); op_valid = 1'b1; op = 3'd2; rs = 32'hFFFF_FFFF; rt = 32'd2;
    @(negedge clk); op_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("abort.busy_mid", busy, 1);
    check("abort.hi_held", hi, 32'h1234_5678);
    op_valid = 1'b1; op = 3'd7;
    #1 check("abort.op7_stall", stall, 0);
    op_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort.busy", busy, 0);
    check("abort.state", state_dbg, 0);
    check("abort.hi", hi, 0);
    check("abort.lo", lo, 0);
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("abort.no_done", done_cnt, 0);
    check("abort.lo_after", lo, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog: never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
